store_unit: RTL

STORE_UNIT -- requirements
Module: store_unit

---
 rtl/vp_dma_pkg.sv | 5 +
 rtl/store_req_buffer.sv | 38 +++
 rtl/store_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/vp_dma_pkg.sv
// Shared types and constants for the vector DMA store path.
package vp_dma_pkg;
  localparam int WORD_W = 32;
  typedef enum logic [1:0] {IDLE, WRITE, DONE} store_state_t;
endpackage

// File: rtl/store_req_buffer.sv
// One-entry pending request slot: captures a vector and its slot number while the writer is busy.
module store_req_buffer #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              i_load,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_full,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_addr
);
  logic              r_full;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] r_addr;

  // Load only happens when empty and pop only when full, so they never coincide.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      r_full <= 1'b0;
      r_data <= '0;
      r_addr <= '0;
    end else if (i_load) begin
      r_full <= 1'b1;
      r_data <= i_data;
      r_addr <= i_addr;
    end else if (i_pop) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;
  assign o_addr = r_addr;
endmodule

// File: rtl/store_unit.sv
// Streams a captured vector into block RAM one 32-bit word per cycle; one pending request may queue behind it.
// States: IDLE = waiting for a request | WRITE = one word per cycle | DONE = done pulse, choose next vector.
module store_unit
  import vp_dma_pkg::*;
#(
  parameter int matSize  = 16,
  parameter int memDepth = 12
) (
  input  logic                          clk,
  input  logic                          RESET,
  input  logic                          inValid,
  output logic                          inReady,
  input  logic [matSize*WORD_W-1:0]     inData,
  input  logic [$clog2(matSize*2)-1:0]  inAddr,
  output logic [memDepth-1:0]           memAddr,
  output logic [WORD_W-1:0]             memData,
  output logic                          memWE,
  output logic                          memEnable,
  output logic                          busy,
  output logic                          done
);
  localparam int SLOT_W       = $clog2(matSize*2);
  localparam int CNT_W        = $clog2(matSize);
  localparam int DATA_W       = matSize * WORD_W;
  localparam int padding_size = memDepth - SLOT_W - CNT_W;

  store_state_t        r_state;
  logic [DATA_W-1:0]   r_active_data;
  logic [SLOT_W-1:0]   r_active_addr;
  logic [CNT_W-1:0]    r_word_cnt;
  logic [memDepth-1:0] r_mem_addr;
  logic [WORD_W-1:0]   r_mem_data;
  logic                r_mem_we;
  logic                r_mem_en;
  logic                r_done;

  logic                w_accept;
  logic                w_pend_load;
  logic                w_pend_pop;
  logic                w_pend_full;
  logic [DATA_W-1:0]   w_pend_data;
  logic [SLOT_W-1:0]   w_pend_addr;
  logic [WORD_W-1:0]   w_word;

  assign inReady  = !w_pend_full;
  assign w_accept = inValid && !w_pend_full;
  // In DONE with an empty slot the new request goes straight to the active register.
  assign w_pend_load = w_accept && (r_state == WRITE);
  assign w_pend_pop  = (r_state == DONE) && w_pend_full;
  assign w_word      = r_active_data[r_word_cnt*WORD_W +: WORD_W];

  store_req_buffer #(
    .DATA_W (DATA_W),
    .ADDR_W (SLOT_W)
  ) u_pend (
    .clk    (clk),
    .RESET  (RESET),
    .i_load (w_pend_load),
    .i_pop  (w_pend_pop),
    .i_data (inData),
    .i_addr (inAddr),
    .o_full (w_pend_full),
    .o_data (w_pend_data),
    .o_addr (w_pend_addr)
  );

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      r_state       <= IDLE;
      r_active_data <= '0;
      r_active_addr <= '0;
      r_word_cnt    <= '0;
      r_mem_addr    <= '0;
      r_mem_data    <= '0;
      r_mem_we      <= 1'b0;
      r_mem_en      <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      r_mem_en <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_active_data <= inData;
            r_active_addr <= inAddr;
            r_word_cnt    <= '0;
            r_state       <= WRITE;
          end
        end
        WRITE: begin
          r_mem_we   <= 1'b1;
          r_mem_en   <= 1'b1;
          r_mem_data <= w_word;
          r_mem_addr <= {{padding_size{1'b0}}, r_active_addr, r_word_cnt};
          r_word_cnt <= r_word_cnt + 1'b1;
          if (r_word_cnt == CNT_W'(matSize-1)) r_state <= DONE;
        end
        DONE: begin
          r_done     <= 1'b1;
          r_word_cnt <= '0;
          if (w_pend_full) begin
            r_active_data <= w_pend_data;
            r_active_addr <= w_pend_addr;
            r_state       <= WRITE;
          end else if (w_accept) begin
            r_active_data <= inData;
            r_active_addr <= inAddr;
            r_state       <= WRITE;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign memAddr   = r_mem_addr;
  assign memData   = r_mem_data;
  assign memWE     = r_mem_we;
  assign memEnable = r_mem_en;
  assign done      = r_done;
  assign busy      = (r_state != IDLE) || w_pend_full;
endmodule
